keccak_sponge_ctrl: RTL and testbench

- Host-side sequencer that drives the masked two-share `keccak1600` core.
- Accepts pre-padded, two-share 32-bit message words on a valid/ready stream and absorbs them block by block. Fills each block with `core_extend` rotations, starts the permutation, and streams squeezed output shares back out.
- Issues further permutations when more output is needed than one rate provides, for extendable output.
- Sits between the bus/DMA front end and the core; the core's `CLK` is shared.

---
 rtl/keccak_sponge_ctrl_pkg.sv | 24 ++
 rtl/keccak_sponge_ctrl_if.sv | 46 ++++
 rtl/keccak_sponge_ctrl.sv | 160 ++++++++++++++++
 tb/tb_keccak_sponge_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_sponge_ctrl_pkg.sv
// Shared constants and state encoding for the host-side keccak sponge sequencer.
package keccak_sponge_ctrl_pkg;

   localparam int STATE_WORDS  = 50;
   localparam int ROUND_CYCLES = 24;

   typedef enum logic [3:0] {
      SP_RST     = 4'd0,
      SP_IDLE    = 4'd1,
      SP_INIT    = 4'd2,
      SP_ABSORB  = 4'd3,
      SP_EXTEND  = 4'd4,
      SP_GO      = 4'd5,
      SP_WAIT    = 4'd6,
      SP_LOAD    = 4'd7,
      SP_SQUEEZE = 4'd8
   } sponge_state_t;

   // A requested length of zero still produces one output word.
   function automatic logic [15:0] eff_out_len(input logic [15:0] len);
      eff_out_len = (len == 16'd0) ? 16'd1 : len;
   endfunction

endpackage

// File: rtl/keccak_sponge_ctrl_if.sv
// Host stream, output stream and core-control bundle of the sponge sequencer.
interface keccak_sponge_ctrl_if;

   logic        start;
   logic [15:0] out_len;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data_0;
   logic [31:0] in_data_1;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data_0;
   logic [31:0] out_data_1;
   logic        busy;
   logic        done;
   logic        core_reset;
   logic        core_init;
   logic        core_go;
   logic        core_squeeze;
   logic        core_in_ready;
   logic        core_absorb;
   logic        core_extend;
   logic [31:0] core_din_0;
   logic [31:0] core_din_1;
   logic        core_done;
   logic [31:0] core_result_0;
   logic [31:0] core_result_1;

   modport slave (
      input  start, out_len, in_valid, in_data_0, in_data_1, in_last, out_ready,
             core_done, core_result_0, core_result_1,
      output in_ready, out_valid, out_data_0, out_data_1, busy, done,
             core_reset, core_init, core_go, core_squeeze, core_in_ready,
             core_absorb, core_extend, core_din_0, core_din_1
   );

   modport master (
      output start, out_len, in_valid, in_data_0, in_data_1, in_last, out_ready,
             core_done, core_result_0, core_result_1,
      input  in_ready, out_valid, out_data_0, out_data_1, busy, done,
             core_reset, core_init, core_go, core_squeeze, core_in_ready,
             core_absorb, core_extend, core_din_0, core_din_1
   );

endinterface

// File: rtl/keccak_sponge_ctrl.sv
// Sequencer for the masked two-share keccak1600 core: absorbs padded blocks,
// realigns the state with extend rotations, permutes, and squeezes output words.
module keccak_sponge_ctrl
   import keccak_sponge_ctrl_pkg::*;
#(
   parameter int RATE_WORDS = 34
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   keccak_sponge_ctrl_if.slave    bus
);

   localparam logic [3:0] ST_RST     = SP_RST;
   localparam logic [3:0] ST_IDLE    = SP_IDLE;
   localparam logic [3:0] ST_INIT    = SP_INIT;
   localparam logic [3:0] ST_ABSORB  = SP_ABSORB;
   localparam logic [3:0] ST_EXTEND  = SP_EXTEND;
   localparam logic [3:0] ST_GO      = SP_GO;
   localparam logic [3:0] ST_WAIT    = SP_WAIT;
   localparam logic [3:0] ST_LOAD    = SP_LOAD;
   localparam logic [3:0] ST_SQUEEZE = SP_SQUEEZE;

   localparam logic [5:0] WC_LAST  = 6'(RATE_WORDS - 1);
   localparam logic [5:0] EXT_LAST = 6'(STATE_WORDS - RATE_WORDS - 1);

   logic [3:0]  state_q, state_d;
   logic [5:0]  wc_q, wc_d;
   logic [5:0]  oc_q, oc_d;
   logic [15:0] rem_q, rem_d;
   logic        last_q, last_d;
   logic        done_d;
   logic        busy_q, done_q, out_valid_q;
   logic        core_reset_q, core_init_q, core_go_q, core_extend_q;
   logic        in_hs_s, out_hs_s;

   assign in_hs_s  = (state_q == ST_ABSORB) && bus.in_valid;
   assign out_hs_s = out_valid_q && bus.out_ready;

   // Next-state and counter logic; wc doubles as the extend-cycle counter.
   always_comb begin
      state_d = state_q;
      wc_d    = wc_q;
      oc_d    = oc_q;
      rem_d   = rem_q;
      last_d  = last_q;
      done_d  = 1'b0;
      case (state_q)
         ST_RST: state_d = ST_IDLE;
         ST_IDLE: begin
            if (bus.start) begin
               rem_d   = eff_out_len(bus.out_len);
               last_d  = 1'b0;
               wc_d    = 6'd0;
               oc_d    = 6'd0;
               state_d = ST_INIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_INIT: state_d = ST_ABSORB;
         ST_ABSORB: begin
            if (in_hs_s) begin
               if (wc_q == WC_LAST) begin
                  wc_d    = 6'd0;
                  last_d  = bus.in_last;
                  state_d = ST_EXTEND;
               end else begin
                  wc_d = wc_q + 6'd1;
               end
            end else begin
               state_d = ST_ABSORB;
            end
         end
         ST_EXTEND: begin
            if (wc_q == EXT_LAST) begin
               wc_d    = 6'd0;
               state_d = ST_GO;
            end else begin
               wc_d = wc_q + 6'd1;
            end
         end
         ST_GO: state_d = ST_WAIT;
         ST_WAIT: begin
            if (bus.core_done) begin
               state_d = last_q ? ST_LOAD : ST_ABSORB;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_LOAD: state_d = ST_SQUEEZE;
         ST_SQUEEZE: begin
            if (out_hs_s) begin
               rem_d = rem_q - 16'd1;
               // Finishing takes priority over a rate-boundary re-permutation.
               if (rem_q == 16'd1) begin
                  done_d  = 1'b1;
                  oc_d    = 6'd0;
                  state_d = ST_IDLE;
               end else if (oc_q == WC_LAST) begin
                  oc_d    = 6'd0;
                  state_d = ST_GO;
               end else begin
                  oc_d = oc_q + 6'd1;
               end
            end else begin
               state_d = ST_SQUEEZE;
            end
         end
         default: state_d = ST_RST;
      endcase
   end

   // State, counters and registered control outputs aligned with the new state.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q       <= ST_RST;
         wc_q          <= 6'd0;
         oc_q          <= 6'd0;
         rem_q         <= 16'd0;
         last_q        <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         out_valid_q   <= 1'b0;
         core_reset_q  <= 1'b1;
         core_init_q   <= 1'b0;
         core_go_q     <= 1'b0;
         core_extend_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wc_q          <= wc_d;
         oc_q          <= oc_d;
         rem_q         <= rem_d;
         last_q        <= last_d;
         busy_q        <= (state_d != ST_IDLE) && (state_d != ST_RST);
         done_q        <= done_d;
         out_valid_q   <= (state_d == ST_SQUEEZE);
         core_reset_q  <= 1'b0;
         core_init_q   <= (state_d == ST_INIT);
         core_go_q     <= (state_d == ST_GO);
         core_extend_q <= (state_d == ST_EXTEND);
      end
   end

   assign bus.in_ready      = (state_q == ST_ABSORB);
   assign bus.core_in_ready = in_hs_s;
   assign bus.core_absorb   = in_hs_s;
   assign bus.core_din_0    = in_hs_s ? bus.in_data_0 : 32'd0;
   assign bus.core_din_1    = in_hs_s ? bus.in_data_1 : 32'd0;
   assign bus.core_squeeze  = out_hs_s;
   assign bus.out_data_0    = bus.core_result_0;
   assign bus.out_data_1    = bus.core_result_1;
   assign bus.out_valid     = out_valid_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.core_reset    = core_reset_q;
   assign bus.core_init     = core_init_q;
   assign bus.core_go       = core_go_q;
   assign bus.core_extend   = core_extend_q;

endmodule

// File: tb/tb_keccak_sponge_ctrl.sv
// Table-driven bench for keccak_sponge_ctrl against a timing-accurate stand-in
// for the keccak1600 core (done 25 cycles after go, result tagged by permutation/word).
module tb_keccak_sponge_ctrl;

   localparam int RATE = 34;

   typedef struct {
      int out_len;
      int blocks;
      bit gaps;
      bit rand_rdy;
      bit busy_start;
      int e_go;
      int e_sq;
      int e_ext;
      int e_abs;
      int e_lat;
   } vec_t;

   logic CLK = 1'b0;
   logic RESET_N;
   int   errors = 0;
   int   checks = 0;
   int   cur_blocks = 1;
   bit   rand_rdy = 1'b0;
   vec_t vecs[9];

   always #5 CLK = ~CLK;

   keccak_sponge_ctrl_if bus();

   keccak_sponge_ctrl #(.RATE_WORDS(RATE)) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .bus     (bus)
   );

   function automatic logic [31:0] res0(input logic [7:0] p, input logic [15:0] i);
      return {8'hC3, p, i};
   endfunction

   function automatic logic [31:0] res1(input logic [7:0] p, input logic [15:0] i);
      return {p, i, 8'h5A} ^ 32'hFFFF_0000;
   endfunction

   // Core stand-in
   logic [5:0]  tmr  = 6'd0;
   logic [7:0]  perm = 8'd0;
   logic [15:0] idx  = 16'd0;

   always @(posedge CLK) begin
      if (bus.core_reset || bus.core_init) begin
         tmr  <= 6'd0;
         perm <= 8'd0;
         idx  <= 16'd0;
      end else if (bus.core_go) begin
         tmr  <= 6'd25;
         perm <= perm + 8'd1;
         idx  <= 16'd0;
      end else begin
         if (tmr != 6'd0) tmr <= tmr - 6'd1;
         if (bus.core_squeeze) idx <= idx + 16'd1;
      end
   end

   assign bus.core_done     = (tmr == 6'd1);
   assign bus.core_result_0 = res0(perm, idx);
   assign bus.core_result_1 = res1(perm, idx);

   // Monitor: cumulative event counts, protocol rules and output scoreboard.
   int n_go = 0, n_sq = 0, n_ext = 0, n_abs = 0, n_done = 0;
   int rule_err = 0, data_err = 0, din_err = 0;
   int cyc = 0, start_cyc = 0, lat = 0, k = 0;
   logic seen_v = 1'b0;
   logic prev_stall = 1'b0;
   logic [31:0] prev_d0 = 32'd0;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (bus.core_go) n_go <= n_go + 1;
      if (bus.core_squeeze) n_sq <= n_sq + 1;
      if (bus.core_extend) n_ext <= n_ext + 1;
      if (bus.done) n_done <= n_done + 1;
      if (bus.core_in_ready) begin
         n_abs <= n_abs + 1;
         if (bus.core_din_0 != bus.in_data_0 || bus.core_din_1 != bus.in_data_1)
            din_err <= din_err + 1;
      end
      if ((bus.core_in_ready && !bus.in_valid) || (bus.core_squeeze && !bus.out_ready) ||
          (bus.core_absorb != bus.core_in_ready) ||
          (prev_stall && RESET_N && (!bus.out_valid || bus.out_data_0 != prev_d0)))
         rule_err <= rule_err + 1;
      prev_stall <= bus.out_valid && !bus.out_ready && RESET_N;
      prev_d0    <= bus.out_data_0;
      if (bus.start && !bus.busy && RESET_N) begin
         start_cyc <= cyc;
         seen_v    <= 1'b0;
         k         <= 0;
      end else if (bus.out_valid) begin
         if (!seen_v) begin
            lat    <= cyc - start_cyc;
            seen_v <= 1'b1;
         end
         if (bus.out_ready) begin
            if (bus.out_data_0 != res0(8'(cur_blocks + k / RATE), 16'(k % RATE)) ||
                bus.out_data_1 != res1(8'(cur_blocks + k / RATE), 16'(k % RATE)))
               data_err <= data_err + 1;
            k <= k + 1;
         end
      end
   end

   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge CLK);
         #1;
         bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic feed(input int blocks, input bit gaps, input bit busy_start);
      int total;
      int t;
      total = blocks * RATE;
      for (int i = 0; i < total; i++) begin
         if (gaps && (i % 3 == 2)) begin
            bus.in_valid = 1'b0;
            @(posedge CLK);
            #1;
         end
         bus.in_valid  = 1'b1;
         bus.in_data_0 = $urandom;
         bus.in_data_1 = bus.in_data_0 ^ (32'(i) * 32'h0100_0193);
         bus.in_last   = (i == total - 1) || (i % RATE == 5);
         if (busy_start && i == 10) begin
            bus.start   = 1'b1;
            bus.out_len = 16'd50;
         end
         t = 0;
         while (!bus.in_ready && t < 500) begin
            @(posedge CLK);
            #1;
            t++;
         end
         if (t >= 500) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL feed_timeout: word %0d not accepted, in_ready=%0d expected 1", i, bus.in_ready);
         end
         @(posedge CLK);
         #1;
         bus.start = 1'b0;
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic run_vector(input int n, input vec_t v);
      int b_go, b_sq, b_ext, b_abs, b_done, b_rule, b_data, b_din;
      bit got;
      b_go = n_go; b_sq = n_sq; b_ext = n_ext; b_abs = n_abs; b_done = n_done;
      b_rule = rule_err; b_data = data_err; b_din = din_err;
      cur_blocks  = v.blocks;
      rand_rdy    = v.rand_rdy;
      bus.out_len = 16'(v.out_len);
      bus.start   = 1'b1;
      @(posedge CLK);
      #1;
      bus.start = 1'b0;
      feed(v.blocks, v.gaps, v.busy_start);
      got = 1'b0;
      for (int c = 0; c < 3000 && !got; c++) begin
         @(posedge CLK);
         #1;
         if (bus.done) got = 1'b1;
      end
      chk($sformatf("v%0d_done_seen", n), int'(got), 1);
      repeat (2) @(posedge CLK);
      #1;
      chk($sformatf("v%0d_core_go", n), n_go - b_go, v.e_go);
      chk($sformatf("v%0d_squeeze", n), n_sq - b_sq, v.e_sq);
      chk($sformatf("v%0d_extend", n), n_ext - b_ext, v.e_ext);
      chk($sformatf("v%0d_absorb", n), n_abs - b_abs, v.e_abs);
      chk($sformatf("v%0d_done_pulses", n), n_done - b_done, 1);
      chk($sformatf("v%0d_latency", n), lat, v.e_lat);
      chk($sformatf("v%0d_data_err", n), data_err - b_data, 0);
      chk($sformatf("v%0d_din_err", n), din_err - b_din, 0);
      chk($sformatf("v%0d_rule_err", n), rule_err - b_rule, 0);
      chk($sformatf("v%0d_busy_after", n), int'(bus.busy), 0);
      rand_rdy = 1'b0;
   endtask

   initial begin
      bit g;
      //            len blk gap rr bs go  sq ext abs lat
      vecs[0] = '{   8, 1, 0, 0, 0, 1,  8, 16, 34,  79};
      vecs[1] = '{   8, 2, 1, 0, 0, 2,  8, 32, 68, 177};
      vecs[2] = '{  40, 1, 0, 0, 0, 2, 40, 16, 34,  79};
      vecs[3] = '{   0, 1, 0, 0, 0, 1,  1, 16, 34,  79};
      vecs[4] = '{  34, 1, 0, 0, 0, 1, 34, 16, 34,  79};
      vecs[5] = '{  35, 1, 0, 1, 0, 2, 35, 16, 34,  79};
      vecs[6] = '{   3, 2, 0, 1, 0, 2,  3, 32, 68, 155};
      vecs[7] = '{   2, 1, 0, 0, 1, 1,  2, 16, 34,  79};
      vecs[8] = '{  69, 1, 0, 1, 0, 3, 69, 16, 34,  79};

      RESET_N       = 1'b0;
      bus.start     = 1'b0;
      bus.out_len   = 16'd0;
      bus.in_valid  = 1'b0;
      bus.in_data_0 = 32'd0;
      bus.in_data_1 = 32'd0;
      bus.in_last   = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_core_reset", int'(bus.core_reset), 1);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_in_ready", int'(bus.in_ready), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_core_go", int'(bus.core_go), 0);
      chk("rst_core_init", int'(bus.core_init), 0);
      chk("rst_core_extend", int'(bus.core_extend), 0);
      @(negedge CLK);
      RESET_N = 1'b1;
      #1;
      chk("rst_cycle_core_reset", int'(bus.core_reset), 1);
      @(posedge CLK);
      #1;
      chk("idle_core_reset", int'(bus.core_reset), 0);
      chk("idle_busy", int'(bus.busy), 0);

      for (int n = 0; n < 9; n++) run_vector(n, vecs[n]);

      // Abort while the core is permuting, then run a clean message.
      cur_blocks  = 1;
      bus.out_len = 16'd8;
      bus.start   = 1'b1;
      @(posedge CLK);
      #1;
      bus.start = 1'b0;
      feed(1, 1'b0, 1'b0);
      g = 1'b0;
      for (int c = 0; c < 200 && !g; c++) begin
         @(posedge CLK);
         #1;
         if (bus.core_go) g = 1'b1;
      end
      chk("midop_go_seen", int'(g), 1);
      repeat (5) @(posedge CLK);
      #1;
      chk("midop_busy_before", int'(bus.busy), 1);
      RESET_N = 1'b0;
      #1;
      chk("midop_core_reset", int'(bus.core_reset), 1);
      chk("midop_busy", int'(bus.busy), 0);
      chk("midop_out_valid", int'(bus.out_valid), 0);
      chk("midop_core_go", int'(bus.core_go), 0);
      chk("midop_in_ready", int'(bus.in_ready), 0);
      chk("midop_done", int'(bus.done), 0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RESET_N = 1'b1;
      @(posedge CLK);
      #1;
      chk("midop_release_core_reset", int'(bus.core_reset), 0);
      run_vector(9, vecs[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
